// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg
//   Shared definitions for the symmetric-FIR coefficient sequencer:
//   default widths and sizes, the controller state encoding, and the
//   delay-line flush length (TAPS+1 cycles).
//   Optional feature macro used by the importing files: FIR_CTRL_READBACK_EN.
package fir_ctrl_pkg;

   localparam int unsigned DEF_COEF_W    = 8;
   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned DEF_NUM_COEFS = 4;
   localparam int unsigned DEF_TAPS      = 7;
   localparam int unsigned FLUSH_LEN     = DEF_TAPS + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // no set ever loaded
      ST_RUN   = 2'd1,   // set loaded, filter output valid
      ST_LOAD  = 2'd2,   // replaying committed set into the filter
      ST_FLUSH = 2'd3    // refilling the delay line after a load
   } state_e;

   // Cycles needed to push a full fresh window through a TAPS-long delay line.
   function automatic int unsigned flush_len(input int unsigned taps);
      return taps + 1;
   endfunction

endpackage

// File: rtl/fir_ctrl_shadow_bank.sv
// fir_ctrl_shadow_bank
//   NUM_COEFS x COEF_W shadow register file filled from the host stream.
//   Writes are ignored while freeze is high. With FIR_CTRL_READBACK_EN
//   defined, an active copy is captured on snap and read back on rb_idx.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   wr_en, wr_idx,  shadow write strobe, index and data
//   wr_data
//   freeze          blocks shadow writes
//   rd_idx, rd_data combinational shadow read (replay path)
//   snap            capture shadow into active copy   (FIR_CTRL_READBACK_EN)
//   rb_idx, rb_data combinational active-copy read     (FIR_CTRL_READBACK_EN)
module fir_ctrl_shadow_bank
   import fir_ctrl_pkg::*;
#(
   parameter int unsigned COEF_W    = DEF_COEF_W,
   parameter int unsigned NUM_COEFS = DEF_NUM_COEFS,
   parameter int unsigned IDX_W     = $clog2(NUM_COEFS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [COEF_W-1:0] wr_data,
   input  logic              freeze,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [COEF_W-1:0] rd_data
`ifdef FIR_CTRL_READBACK_EN
   ,
   input  logic              snap,
   input  logic [IDX_W-1:0]  rb_idx,
   output logic [COEF_W-1:0] rb_data
`endif
);

   logic [COEF_W-1:0] shadow_q [NUM_COEFS];
   logic [COEF_W-1:0] shadow_d [NUM_COEFS];

   always_comb begin
      shadow_d = shadow_q;
      if (wr_en && !freeze) shadow_d[wr_idx] = wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_COEFS; i++) shadow_q[i] <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end

   always_comb rd_data = shadow_q[rd_idx];

`ifdef FIR_CTRL_READBACK_EN
   logic [COEF_W-1:0] active_q [NUM_COEFS];

   // Snap samples shadow_d so the final beat written on the commit edge is included.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_COEFS; i++) active_q[i] <= '0;
      end else if (snap) begin
         active_q <= shadow_d;
      end
   end

   always_comb rb_data = active_q[rb_idx];
`endif

endmodule

// File: rtl/fir_sym_coef_ctrl.sv
// fir_sym_coef_ctrl
//   Configuration sequencer for a 7-tap symmetric FIR (4 unique coefs).
//   Collects a coefficient set from the host stream, checks its length,
//   replays a committed set into the filter coefficient port, zero-stuffs
//   and refills the delay line, and qualifies the filter output.
//   Optional readback of the active set: define FIR_CTRL_READBACK_EN.
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   cfg_valid/ready/data/last     host coefficient stream
//   cfg_err                       one-cycle pulse, malformed set dropped
//   x_valid, x_data, x_ready      sample source handshake
//   fir_x_in, fir_coef, fir_wen,  to filter x_in / coef_val / writeen / tlast
//   fir_tlast
//   out_valid                     filter output is from a full fresh window
//   busy                          LOAD or FLUSH in progress
//   rb_idx, rb_data               active-set readback (FIR_CTRL_READBACK_EN)
module fir_sym_coef_ctrl
   import fir_ctrl_pkg::*;
#(
   parameter int unsigned COEF_W    = DEF_COEF_W,
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned NUM_COEFS = DEF_NUM_COEFS,
   parameter int unsigned TAPS      = DEF_TAPS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_valid,
   output logic                         cfg_ready,
   input  logic [COEF_W-1:0]            cfg_data,
   input  logic                         cfg_last,
   output logic                         cfg_err,
   input  logic                         x_valid,
   input  logic [DATA_W-1:0]            x_data,
   output logic                         x_ready,
   output logic [DATA_W-1:0]            fir_x_in,
   output logic [COEF_W-1:0]            fir_coef,
   output logic                         fir_wen,
   output logic                         fir_tlast,
   output logic                         out_valid,
   output logic                         busy
`ifdef FIR_CTRL_READBACK_EN
   ,
   input  logic [$clog2(NUM_COEFS)-1:0] rb_idx,
   output logic [COEF_W-1:0]            rb_data
`endif
);

   localparam int unsigned IDX_W   = $clog2(NUM_COEFS);
   localparam int unsigned FLUSH_N = flush_len(TAPS);
   localparam int unsigned CNT_MAX = (FLUSH_N > NUM_COEFS) ? FLUSH_N : NUM_COEFS;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
   logic              err_q, err_d;
   logic              cfg_err_q, cfg_err_d;
   logic              collect, beat, at_end, bank_wr;
   logic [COEF_W-1:0] bank_rd;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         wr_idx_q  <= '0;
         err_q     <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_idx_q  <= wr_idx_d;
         err_q     <= err_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_idx_d  = wr_idx_q;
      err_d     = err_q;
      cfg_err_d = 1'b0;
      bank_wr   = 1'b0;
      collect   = (state_q == ST_IDLE) || (state_q == ST_RUN);
      beat      = cfg_valid && collect;
      at_end    = (wr_idx_q == IDX_W'(NUM_COEFS - 1));
      case (state_q)
         ST_IDLE, ST_RUN: begin
            if (beat) begin
               if (err_q) begin
                  // Overlong set: discard beats until its last one.
                  if (cfg_last) begin
                     cfg_err_d = 1'b1;
                     wr_idx_d  = '0;
                     err_d     = 1'b0;
                  end
               end else begin
                  bank_wr = 1'b1;
                  if (cfg_last) begin
                     wr_idx_d = '0;
                     if (at_end) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                     end else begin
                        cfg_err_d = 1'b1;
                     end
                  end else if (at_end) begin
                     err_d = 1'b1;
                  end else begin
                     wr_idx_d = wr_idx_q + 1'b1;
                  end
               end
            end
         end
         ST_LOAD: begin
            if (cnt_q == CNT_W'(NUM_COEFS - 1)) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == CNT_W'(FLUSH_N - 1)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      cfg_ready = 1'b0;
      x_ready   = 1'b1;
      fir_x_in  = '0;
      fir_coef  = '0;
      fir_wen   = 1'b0;
      fir_tlast = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      cfg_err   = cfg_err_q;
      case (state_q)
         ST_IDLE: cfg_ready = 1'b1;
         ST_RUN: begin
            cfg_ready = 1'b1;
            out_valid = 1'b1;
         end
         ST_LOAD: begin
            x_ready   = 1'b0;
            fir_wen   = 1'b1;
            fir_coef  = bank_rd;
            fir_tlast = (cnt_q == CNT_W'(NUM_COEFS - 1));
            busy      = 1'b1;
         end
         ST_FLUSH: busy = 1'b1;
         default: ;
      endcase
      if (x_valid && x_ready) fir_x_in = x_data;
   end

`ifdef FIR_CTRL_READBACK_EN
   logic bank_snap;
   assign bank_snap = (state_d == ST_LOAD) && (state_q != ST_LOAD);
`endif

   fir_ctrl_shadow_bank #(
      .COEF_W    (COEF_W),
      .NUM_COEFS (NUM_COEFS),
      .IDX_W     (IDX_W)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bank_wr),
      .wr_idx  (wr_idx_q),
      .wr_data (cfg_data),
      .freeze  (busy),
      .rd_idx  (cnt_q[IDX_W-1:0]),
      .rd_data (bank_rd)
`ifdef FIR_CTRL_READBACK_EN
      ,
      .snap    (bank_snap),
      .rb_idx  (rb_idx),
      .rb_data (rb_data)
`endif
   );

endmodule

// File: tb/tb_fir_sym_coef_ctrl.sv
// tb_fir_sym_coef_ctrl
//   Bench for fir_sym_coef_ctrl: directed scenarios plus randomized sets and
//   samples, checked every cycle against a set/timeline model.
//   Readback checks are included when FIR_CTRL_READBACK_EN is defined.
module tb_fir_sym_coef_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_valid = 1'b0, cfg_last = 1'b0;
   logic [7:0] cfg_data = '0;
   logic       cfg_ready, cfg_err;
   logic       x_valid = 1'b0;
   logic [7:0] x_data = '0;
   logic       x_ready;
   logic [7:0] fir_x_in, fir_coef;
   logic       fir_wen, fir_tlast, out_valid, busy;
`ifdef FIR_CTRL_READBACK_EN
   logic [1:0] rb_idx = '0;
   logic [7:0] rb_data;
`endif

   always #5 clk = ~clk;

   fir_sym_coef_ctrl #(
      .COEF_W(8), .DATA_W(8), .NUM_COEFS(4), .TAPS(7)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
      .cfg_last(cfg_last), .cfg_err(cfg_err),
      .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
      .fir_x_in(fir_x_in), .fir_coef(fir_coef), .fir_wen(fir_wen),
      .fir_tlast(fir_tlast), .out_valid(out_valid), .busy(busy)
`ifdef FIR_CTRL_READBACK_EN
      , .rb_idx(rb_idx), .rb_data(rb_data)
`endif
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A set is the list of beats since the previous last; exactly 4 beats
   // commits it. A commit schedules a 12-cycle busy timeline (4 coefficient
   // writes, then 8 flush cycles); output is valid once a timeline has
   // completed and none is pending.
   typedef struct {
      bit         load;
      logic [7:0] coef;
      bit         tlast;
   } rec_t;

   rec_t       exp_q[$];
   logic [7:0] set_q[$];
   bit         loaded = 1'b0;
   bit         err_exp = 1'b0;
   logic [7:0] act_m[4] = '{default: 8'h00};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         set_q.delete();
         loaded  = 1'b0;
         err_exp = 1'b0;
         for (int i = 0; i < 4; i++) act_m[i] = 8'h00;
      end else begin
         err_exp = 1'b0;
         if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) loaded = 1'b1;
         end else if (cfg_valid) begin
            set_q.push_back(cfg_data);
            if (cfg_last) begin
               if (set_q.size() == 4) begin
                  for (int k = 0; k < 4; k++) begin
                     exp_q.push_back('{1'b1, set_q[k], (k == 3)});
                     act_m[k] = set_q[k];
                  end
                  for (int k = 0; k < 8; k++) exp_q.push_back('{1'b0, 8'h00, 1'b0});
               end else begin
                  err_exp = 1'b1;
               end
               set_q.delete();
            end
         end
      end
   end

   // Every-cycle compare against the model
   always @(negedge clk) begin
      rec_t r;
      bit   b;
      b = (exp_q.size() != 0);
      if (b) r = exp_q[0];
      else   r = '{1'b0, 8'h00, 1'b0};
      chk("cfg_ready", 32'(cfg_ready), 32'(!b));
      chk("busy",      32'(busy),      32'(b));
      chk("out_valid", 32'(out_valid), 32'(loaded && !b));
      chk("cfg_err",   32'(cfg_err),   32'(err_exp));
      chk("fir_wen",   32'(fir_wen),   32'(r.load));
      chk("fir_coef",  32'(fir_coef),  32'(r.coef));
      chk("fir_tlast", 32'(fir_tlast), 32'(r.tlast));
      chk("x_ready",   32'(x_ready),   32'(!r.load));
      chk("fir_x_in",  32'(fir_x_in),  32'((x_valid && !r.load) ? x_data : 8'h00));
`ifdef FIR_CTRL_READBACK_EN
      chk("rb_data",   32'(rb_data),   32'(act_m[rb_idx]));
`endif
   end

   // ---------------- event monitor for directed literals ----------------
   int         cyc = 0, err_cnt = 0, ov_cnt = 0, last_cyc = 0, rise_cyc = 0;
   bit         ov_prev = 1'b0;
   logic [7:0] wen_coef[$];
   bit         wen_tl[$];

   always @(negedge clk) begin
      cyc++;
      if (fir_wen) begin
         wen_coef.push_back(fir_coef);
         wen_tl.push_back(fir_tlast);
      end
      if (cfg_err) err_cnt++;
      if (out_valid) ov_cnt++;
      if (cfg_valid && cfg_ready && cfg_last) last_cyc = cyc;
      if (out_valid && !ov_prev) rise_cyc = cyc;
      ov_prev = out_valid;
   end

   // ---------------- drivers ----------------
   bit x_rand = 1'b0;

   initial forever begin
      @(posedge clk);
      #2;
      if (x_rand) begin
         x_valid = 1'($urandom_range(0, 1));
         x_data  = 8'($urandom);
`ifdef FIR_CTRL_READBACK_EN
         rb_idx  = 2'($urandom_range(0, 3));
`endif
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Holds the beat until accepted (bounded).
   task automatic send_beat(input logic [7:0] d, input bit last);
      int n;
      bit acc;
      cfg_valid = 1'b1;
      cfg_data  = d;
      cfg_last  = last;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = cfg_ready;
         @(posedge clk);
         #2;
         n++;
      end
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      chk("beat_accepted", 32'(acc), 32'd1);
   endtask

   task automatic send_set(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
      send_beat(a, 1'b0);
      send_beat(b, 1'b0);
      send_beat(c, 1'b0);
      send_beat(d, 1'b1);
   endtask

   task automatic wait_ov(input int budget);
      int n;
      n = 0;
      while (!out_valid && n < budget) begin
         idle(1);
         n++;
      end
      chk("out_valid_wait", 32'(out_valid), 32'd1);
      idle(1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e, w, o;
      // Reset values
      #12;
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("rst_x_ready",   32'(x_ready),   32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_fir_wen",   32'(fir_wen),   32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      idle(2);
      rst = 1'b0;
      idle(2);

      // 1: first load and latency
      w = wen_coef.size();
      send_set(8'd1, 8'd2, 8'd3, 8'd4);
      wait_ov(40);
      chk("t1_latency", 32'(rise_cyc - last_cyc), 32'd13);
      chk("t1_wen_cnt", 32'(wen_coef.size() - w), 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk("t1_coef",  32'(wen_coef[w+k]), 32'(k + 1));
         chk("t1_tlast", 32'(wen_tl[w+k]),   32'(k == 3));
      end

      // 2: short set rejected while running
      e = err_cnt;
      w = wen_coef.size();
      send_beat(8'd5, 1'b0);
      send_beat(8'd6, 1'b0);
      send_beat(8'd7, 1'b1);
      idle(3);
      chk("t2_err_pulses", 32'(err_cnt - e), 32'd1);
      chk("t2_no_wen",     32'(wen_coef.size() - w), 32'd0);
      chk("t2_out_valid",  32'(out_valid), 32'd1);

      // 2/4: 9,9,9,9 loads; during LOAD samples blocked; next set stalls
      send_set(8'd9, 8'd9, 8'd9, 8'd9);
      x_valid = 1'b1;
      x_data  = 8'hFF;
      #1;
      chk("t4_x_ready",   32'(x_ready),   32'd0);
      chk("t4_fir_x_in",  32'(fir_x_in),  32'd0);
      chk("t4_cfg_ready", 32'(cfg_ready), 32'd0);
      send_set(8'hA1, 8'hA2, 8'hA3, 8'hA4);
      x_valid = 1'b0;
      wait_ov(40);
      chk("t4_wen_cnt", 32'(wen_coef.size() - w), 32'd8);
      for (int k = 0; k < 4; k++) begin
         chk("t2_coef9",  32'(wen_coef[w+k]),   32'd9);
         chk("t4_coefA",  32'(wen_coef[w+4+k]), 32'(8'hA1 + k));
      end

      // 3: overlong set, single error after the final beat only
      e = err_cnt;
      w = wen_coef.size();
      for (int k = 0; k < 4; k++) send_beat(8'(k + 1), 1'b0);
      idle(3);
      chk("t3_no_early_err", 32'(err_cnt - e), 32'd0);
      send_beat(8'd5, 1'b1);
      idle(3);
      chk("t3_err_pulses", 32'(err_cnt - e), 32'd1);
      chk("t3_no_wen",     32'(wen_coef.size() - w), 32'd0);
      chk("t3_out_valid",  32'(out_valid), 32'd1);

`ifdef FIR_CTRL_READBACK_EN
      // 6: active copy survives an erroneous set
      send_set(8'h11, 8'h22, 8'h33, 8'h44);
      wait_ov(40);
      send_beat(8'h55, 1'b0);
      send_beat(8'h66, 1'b1);
      idle(3);
      for (int k = 0; k < 4; k++) begin
         rb_idx = 2'(k);
         #1;
         chk("t6_rb_data", 32'(rb_data), 32'(8'h11 * (k + 1)));
      end
      idle(1);
`endif

      // 5: reset in the 2nd LOAD cycle
      send_set(8'd1, 8'd2, 8'd3, 8'd4);
      idle(1);
      chk("t5_in_load", 32'(fir_wen), 32'd1);
      rst = 1'b1;
      #1;
      chk("t5_fir_wen",   32'(fir_wen),   32'd0);
      chk("t5_fir_coef",  32'(fir_coef),  32'd0);
      chk("t5_fir_tlast", 32'(fir_tlast), 32'd0);
      chk("t5_busy",      32'(busy),      32'd0);
      chk("t5_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("t5_out_valid", 32'(out_valid), 32'd0);
      w = wen_coef.size();
      o = ov_cnt;
      idle(2);
      rst = 1'b0;
      idle(25);
      chk("t5_no_wen", 32'(wen_coef.size() - w), 32'd0);
      chk("t5_no_ov",  32'(ov_cnt - o), 32'd0);

      // Randomized sets and samples
      x_rand = 1'b1;
      for (int s = 0; s < 60; s++) begin
         int len;
         len = ($urandom_range(0, 9) < 6) ? 4 : int'($urandom_range(1, 6));
         for (int b = 0; b < len; b++) send_beat(8'($urandom), (b == len - 1));
         idle(int'($urandom_range(0, 3)));
      end
      idle(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
